// File: rtl/imem_dmem_responder.sv
// imem_dmem_responder
// Memory-side responder for the CPU pipeline. The memory is word-addressed and
// 16 bits wide, with 2**AW words. It has two read ports with a fixed latency and
// one synchronous write port.
//
// Parameters
//   AW       word address width; the array holds 2**AW words
//   RD_LAT   read latency in cycles from issue to valid rdata (1..4)
//   HEX_FILE image file name (no image is loaded in this build)
//
// The array powers up undefined; only writes define its contents.
//
// Ports
//   clk, rst                  rising-edge clock; synchronous active-high reset
//   ren0, raddr0              port-0 (fetch) read request and word address
//   hold0                     freezes the port-0 pipeline and its outputs
//   flush0                    kills in-flight port-0 reads; a same-cycle ren0 is kept
//   rvalid0, rdata0           port-0 response; rdata0 holds its last valid value
//   ren1, raddr1              port-1 (load) read request and word address, no backpressure
//   rvalid1, rdata1           port-1 response; rdata1 holds its last valid value
//   wen, waddr, wdata         single-cycle write, committed at the clock edge
module imem_dmem_responder #(
  parameter int unsigned AW       = 15,
  parameter int unsigned RD_LAT   = 2,
  parameter string       HEX_FILE = "mem.hex"
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ren0,
  input  logic [AW-1:0] raddr0,
  input  logic          hold0,
  input  logic          flush0,
  output logic          rvalid0,
  output logic [15:0]   rdata0,
  input  logic          ren1,
  input  logic [AW-1:0] raddr1,
  output logic          rvalid1,
  output logic [15:0]   rdata1,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata
);

  logic [15:0] mem [2**AW];

  if (HEX_FILE == "") begin : g_no_image
  end

  always_ff @(posedge clk) begin
    if (!rst && wen) begin
      mem[waddr] <= wdata;
    end
  end

  logic [15:0] rd0;
  logic [15:0] rd1;

  always_comb begin
    rd0 = mem[raddr0];
    rd1 = mem[raddr1];
    if (wen && (waddr == raddr0)) begin
      rd0 = wdata;
    end
    if (wen && (waddr == raddr1)) begin
      rd1 = wdata;
    end
  end

  logic        v0 [RD_LAT];
  logic [15:0] d0 [RD_LAT];
  logic        v1 [RD_LAT];
  logic [15:0] d1 [RD_LAT];

  logic adv0;
  assign adv0 = flush0 || !hold0;

  for (genvar i = 0; i < RD_LAT; i++) begin : g_p0
    logic        in_v;
    logic [15:0] in_d;

    if (i == 0) begin : g_head
      assign in_v = ren0;
      assign in_d = rd0;
    end else begin : g_body
      assign in_v = v0[i-1] && !flush0;
      assign in_d = d0[i-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v0[i] <= 1'b0;
        d0[i] <= '0;
      end else if (adv0) begin
        v0[i] <= in_v;
        if (in_v) begin
          d0[i] <= in_d;
        end
      end
    end
  end

  for (genvar i = 0; i < RD_LAT; i++) begin : g_p1
    logic        in_v;
    logic [15:0] in_d;

    if (i == 0) begin : g_head
      assign in_v = ren1;
      assign in_d = rd1;
    end else begin : g_body
      assign in_v = v1[i-1];
      assign in_d = d1[i-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v1[i] <= 1'b0;
        d1[i] <= '0;
      end else begin
        v1[i] <= in_v;
        if (in_v) begin
          d1[i] <= in_d;
        end
      end
    end
  end

  assign rvalid0 = v0[RD_LAT-1];
  assign rdata0  = d0[RD_LAT-1];
  assign rvalid1 = v1[RD_LAT-1];
  assign rdata1  = d1[RD_LAT-1];

endmodule
